// File: rtl/decay_tau_meter_if.sv
// decay_tau_meter_if: control, sample and result bundle between a measurement master and the tau meter
interface decay_tau_meter_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic             abort;
  logic             sample_en;
  logic [11:0]      sample;
  logic             meas_ack;
  logic             busy;
  logic             meas_valid;
  logic [CNT_W-1:0] tau;
  logic [11:0]      v0;
  logic             timeout;
  modport master (
    output start, abort, sample_en, sample, meas_ack,
    input  busy, meas_valid, tau, v0, timeout
  );
  modport slave (
    input  start, abort, sample_en, sample, meas_ack,
    output busy, meas_valid, tau, v0, timeout
  );
endinterface

// File: rtl/decay_tau_meter.sv
// decay_tau_meter: measures an exponential decay time constant in samples (optional DECAY_TAU_METER_FILTER_EN needs two consecutive samples at/below threshold)
module decay_tau_meter #(
  parameter int unsigned THR_NUM   = 94,
  parameter int          CNT_W     = 16,
  parameter int unsigned MAX_COUNT = 65535
) (
  input logic                clk,
  input logic                reset_n,
  decay_tau_meter_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, CAPTURE, TRACK, DONE} state_t;
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_COUNT);
  state_t           state;
  logic             busy, meas_valid, timeout;
  logic [CNT_W-1:0] tau, count, nxt;
  logic [11:0]      v0, vth;
  logic [19:0]      prod;
  logic             le;
`ifdef DECAY_TAU_METER_FILTER_EN
  logic             pend;
  logic [CNT_W-1:0] ptau;
`endif
  assign prod = 20'(bus.sample) * 20'(THR_NUM);
  assign le   = bus.sample <= vth;
  assign nxt  = count + CNT_W'(1);
  assign bus.busy       = busy;
  assign bus.meas_valid = meas_valid;
  assign bus.tau        = tau;
  assign bus.v0         = v0;
  assign bus.timeout    = timeout;
  // measurement sequencer: capture V0, count samples to the threshold crossing, hold result until ack
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      meas_valid <= 1'b0;
      timeout    <= 1'b0;
      tau        <= '0;
      v0         <= '0;
      vth        <= '0;
      count      <= '0;
`ifdef DECAY_TAU_METER_FILTER_EN
      pend       <= 1'b0;
      ptau       <= '0;
`endif
    end else if (bus.abort) begin
      state      <= IDLE;
      busy       <= 1'b0;
      meas_valid <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          state <= CAPTURE;
          busy  <= 1'b1;
        end
        CAPTURE: if (bus.sample_en) begin
          v0      <= bus.sample;
          vth     <= prod[19:8];
          count   <= '0;
          timeout <= 1'b0;
`ifdef DECAY_TAU_METER_FILTER_EN
          pend    <= 1'b0;
`endif
          if (bus.sample == 12'd0) begin
            state      <= DONE;
            tau        <= '0;
            busy       <= 1'b0;
            meas_valid <= 1'b1;
          end else
            state <= TRACK;
        end
        TRACK: if (bus.sample_en) begin
`ifdef DECAY_TAU_METER_FILTER_EN
          if (le && pend) begin
            state      <= DONE;
            tau        <= ptau;
            busy       <= 1'b0;
            meas_valid <= 1'b1;
          end else if (nxt == MAX_C) begin
            state      <= DONE;
            tau        <= MAX_C;
            timeout    <= 1'b1;
            busy       <= 1'b0;
            meas_valid <= 1'b1;
          end else begin
            count <= nxt;
            pend  <= le;
            ptau  <= le ? nxt : ptau;
          end
`else
          if (le) begin
            state      <= DONE;
            tau        <= nxt;
            busy       <= 1'b0;
            meas_valid <= 1'b1;
          end else if (nxt == MAX_C) begin
            state      <= DONE;
            tau        <= MAX_C;
            timeout    <= 1'b1;
            busy       <= 1'b0;
            meas_valid <= 1'b1;
          end else
            count <= nxt;
`endif
        end
        DONE: if (bus.meas_ack) begin
          state      <= IDLE;
          meas_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_decay_tau_meter.sv
// tb_decay_tau_meter: randomized decay waveforms checked against a sample-list reference model
module tb_decay_tau_meter;
  localparam int THR = 94, CW = 16, MAXC = 8;
  logic clk = 1'b0, reset_n = 1'b0;
  int   errors = 0, checks = 0;
  int   seq [0:MAXC];
  always #5 clk = ~clk;
  decay_tau_meter_if #(.CNT_W(CW)) bus ();
  decay_tau_meter #(.THR_NUM(THR), .CNT_W(CW), .MAX_COUNT(MAXC)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  // reference: tau is the 1-based index of the first TRACK sample at/below V0*THR/256
  function automatic void model(output int tau, output int to, output int n);
    int vth;
    tau = 0; to = 0; n = 1;
    if (seq[0] == 0) return;
    vth = seq[0] * THR / 256;
    for (int k = 1; k <= MAXC; k++) begin
      n = k + 1;
`ifdef DECAY_TAU_METER_FILTER_EN
      if (k >= 2 && seq[k] <= vth && seq[k-1] <= vth) begin tau = k - 1; return; end
`else
      if (seq[k] <= vth) begin tau = k; return; end
`endif
      if (k == MAXC) begin tau = MAXC; to = 1; return; end
    end
  endfunction
  task automatic gap(input bit noisy);
    repeat ($urandom_range(0, 2)) begin
      bus.sample_en = 1'b0;
      bus.sample    = 12'($urandom);
      bus.start     = noisy & 1'($urandom);
      bus.meas_ack  = noisy & 1'($urandom);
      tick;
      bus.start    = 1'b0;
      bus.meas_ack = 1'b0;
      check("busy_in_gap", bus.busy, 1);
    end
  endtask
  task automatic run(input string name, input bit noisy);
    int tau, to, n;
    model(tau, to, n);
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    check({name, "_busy"}, bus.busy, 1);
    for (int i = 0; i < n; i++) begin
      gap(noisy);
      bus.sample    = 12'(seq[i]);
      bus.sample_en = 1'b1;
      tick;
      bus.sample_en = 1'b0;
      if (i < n - 1) check({name, "_early_valid"}, bus.meas_valid, 0);
    end
    check({name, "_valid"}, bus.meas_valid, 1);
    check({name, "_tau"}, bus.tau, tau);
    check({name, "_timeout"}, bus.timeout, to);
    check({name, "_v0"}, bus.v0, seq[0]);
    check({name, "_busy_done"}, bus.busy, 0);
    repeat ($urandom_range(1, 3)) begin
      bus.start = 1'($urandom);
      tick;
      bus.start = 1'b0;
      check({name, "_hold_valid"}, bus.meas_valid, 1);
      check({name, "_hold_tau"}, bus.tau, tau);
    end
    bus.meas_ack = 1'b1;
    tick;
    bus.meas_ack = 1'b0;
    check({name, "_ack_valid"}, bus.meas_valid, 0);
    check({name, "_ack_tau"}, bus.tau, tau);
  endtask
  task automatic load(input int a, b, c, d, e, input int pad);
    for (int k = 0; k <= MAXC; k++) seq[k] = pad;
    seq[0] = a; seq[1] = b; seq[2] = c; seq[3] = d; seq[4] = e;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bus.start = 1'b0; bus.abort = 1'b0; bus.sample_en = 1'b0;
    bus.sample = '0; bus.meas_ack = 1'b0;
    repeat (2) tick;
    check("rst_busy", bus.busy, 0);
    check("rst_valid", bus.meas_valid, 0);
    check("rst_tau", bus.tau, 0);
    check("rst_v0", bus.v0, 0);
    check("rst_timeout", bus.timeout, 0);
    reset_n = 1'b1;
    tick;
    load(2048, 1500, 1000, 800, 752, 700);
    run("nominal", 1'b0);
    load(2048, 1500, 1000, 800, 752, 700);
    run("nominal_gaps", 1'b1);
    load(2000, 2000, 2000, 2000, 2000, 2000);
    run("timeout", 1'b0);
    load(0, 5, 5, 5, 5, 5);
    run("zero", 1'b0);
`ifdef DECAY_TAU_METER_FILTER_EN
    load(2048, 752, 760, 700, 690, 600);
    run("filter", 1'b0);
`endif
    bus.start = 1'b1; tick; bus.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.sample = 12'(2048 - 300 * i); bus.sample_en = 1'b1; tick;
    end
    bus.sample = 12'd700; bus.abort = 1'b1; tick;
    bus.abort = 1'b0; bus.sample_en = 1'b0;
    check("abort_valid", bus.meas_valid, 0);
    check("abort_busy", bus.busy, 0);
    check("abort_timeout", bus.timeout, 0);
    check("abort_v0", bus.v0, 2048);
    repeat (2) tick;
    check("abort_idle_valid", bus.meas_valid, 0);
    load(1024, 600, 376, 300, 300, 300);
    run("abort_rerun", 1'b0);
    bus.start = 1'b1; tick; bus.start = 1'b0;
    bus.sample = 12'd3000; bus.sample_en = 1'b1; tick; bus.sample_en = 1'b0;
    #3 reset_n = 1'b0;
    #1;
    check("async_rst_busy", bus.busy, 0);
    check("async_rst_v0", bus.v0, 0);
    tick;
    reset_n = 1'b1;
    tick;
    for (int r = 0; r < 40; r++) begin
      seq[0] = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 4095));
      for (int k = 1; k <= MAXC; k++) begin
        int p, d;
        p = seq[k-1];
        d = $urandom_range(0, p / 3 + 1);
        seq[k] = ($urandom_range(0, 4) == 0) ? ((p + d > 4095) ? 4095 : p + d) : ((p > d) ? p - d : 0);
      end
      run($sformatf("rand%0d", r), 1'($urandom));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/decay_tau_meter.md
# decay_tau_meter

Measurement block that reads the 12-bit output waveform of the fixed-point analog integrator models (e.g. the low-high-low evaluator) and extracts its exponential time constant in sample periods. After an arm pulse it captures the initial value V0, computes a threshold V0·THR_NUM/256 (≈1/e for the default), counts samples until the waveform falls to or below that threshold, and presents the count with a valid/ack handshake. It sits beside the integrator in the verification and calibration path.

## Interface
- THR_NUM, 94: threshold fraction numerator over 256, 8-bit unsigned (94/256 ≈ 0.367).
- CNT_W, 16: width of the sample counter and result.
- MAX_COUNT, 65535: timeout limit in samples (1 ≤ MAX_COUNT ≤ 2^CNT_W−1).
- clk  in  1  single clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  arm pulse; accepted only in IDLE.
- abort  in  1  synchronous abort; returns to IDLE from any state.
- sample_en  in  1  qualifies `sample` (one integrator update).
- sample  in  12  unsigned waveform value.
- meas_ack  in  1  consumer acknowledges the result.
- busy  out  1  high in CAPTURE and TRACK.
- meas_valid  out  1  result available; high only in DONE.
- tau  out  CNT_W  measured time constant in samples.
- v0  out  12  captured initial value.
- timeout  out  1  result hit MAX_COUNT without crossing.

## Operation
- States: IDLE, CAPTURE, TRACK, DONE. All outputs registered; every output resets to 0, FSM to IDLE.
- IDLE: start=1 → CAPTURE. tau/v0/timeout keep last result.
- CAPTURE: waits for sample_en. On it: v0 ← sample; vth ← (sample·THR_NUM)>>8 (20-bit product, bits [19:8], truncation); count ← 0; timeout ← 0. If sample==0 → DONE with tau=0; else → TRACK.
- TRACK, on sample_en (other cycles hold): if sample ≤ vth → DONE, tau ← count+1. Else if count+1 == MAX_COUNT → DONE, tau ← MAX_COUNT, timeout ← 1. Else count ← count+1. Comparison is unsigned.
- DONE: meas_valid=1, tau/v0/timeout stable. meas_ack=1 → IDLE, meas_valid falls next cycle. start ignored in DONE.
- start while busy: ignored. meas_ack outside DONE: ignored.
- abort (highest priority, over start/ack/sample_en): → IDLE next cycle, meas_valid←0, timeout←0; tau/v0 hold.
- Simultaneous crossing and MAX_COUNT in the same sample: crossing wins, timeout=0.

## Timing
- start in cycle n → busy=1 from n+1.
- First sample_en in CAPTURE is V0 (not counted); each later sample_en in TRACK counts one.
- Crossing sample at cycle m → meas_valid=1 and tau valid from m+1.
- ack in cycle k → meas_valid=0 at k+1; a new start is accepted at k+1 earliest.
- reset_n deassertion mid-measurement is not special: any reset_n low clears immediately (async).

## Configuration
- DECAY_TAU_METER_FILTER_EN defined: crossing requires two consecutive qualifying TRACK samples ≤ vth; tau = count index of the first of the pair (count+1 at that sample); a sample > vth between them clears the pending flag; result appears one sample later than without the macro. Timeout still checked on every sample; timeout with a pending flag reports timeout=1.
- Not defined: single sample ≤ vth ends the measurement as above.

## Test plan
- Nominal: start, samples 2048,1500,1000,800,752 → vth=752, v0=2048, tau=4, timeout=0, meas_valid one cycle after 752 sample; holds until ack.
- Timeout (MAX_COUNT=8): V0=2000 then constant 2000 → DONE after 8th TRACK sample, tau=8, timeout=1.
- Zero start: V0 sample 0 → DONE next cycle, tau=0, timeout=0, v0=0.
- Abort at 3rd TRACK sample, then start again with 1024,600,376 → first run produces no meas_valid; second gives vth=376, tau=2.
- Gaps and ignored controls: sample_en low between samples, start pulsed during TRACK, ack pulsed in TRACK → tau unchanged vs gapless run, no restart.
- With DECAY_TAU_METER_FILTER_EN: 2048,752,760,700,690 → 752 alone doesn't finish; pair 700,690 → tau=3, meas_valid one cycle after 690.
